// File: rtl/sc_regbank_multimode.sv
//------------------------------------------------------------------------------
// sc_regbank_multimode
// Register file between the bus and the ALU: REG_COUNT registers of
// DATAWIDTH_BUS bits. It has one write/operate port, which does one of load,
// shl, shr or inc per falling clock edge. It also has two combinational read
// ports, registered carry and zero flags, and one dirty bit per register.
//
// Optional build macro: SC_REGBANK_READ_BYPASS_EN
//   defined   -> a read port whose address matches a valid pending write shows
//                the operation result before the edge
//   undefined -> read ports always show stored contents
//
// Ports:
//   SC_RegBANK_CLOCK_50          clock, all state changes on the falling edge
//   SC_RegGENERAL_Reset_InHigh   async active-high reset
//   SC_RegBANK_Write_InHigh      execute Op on WrAddr this edge
//   SC_RegBANK_Op_In             00 load, 01 shl, 10 shr, 11 inc
//   SC_RegBANK_WrAddr_In         target register
//   SC_RegBANK_DataBUS_In        load data
//   SC_RegBANK_ClearDirty_InHigh clear all dirty bits (a same-cycle write wins)
//   SC_RegBANK_RdAddrA/B_In      read addresses
//   SC_RegBANK_DataBUSA/B_Out    read data, 0 for out-of-range addresses
//   SC_RegBANK_Carry_Out         carry/shift-out of last executed operation
//   SC_RegBANK_Zero_Out          last executed result was zero
//   SC_RegBANK_Dirty_Out         per-register written-since-clear bits
//------------------------------------------------------------------------------
module sc_regbank_multimode #(
  parameter int DATAWIDTH_BUS    = 32,
  parameter int REG_COUNT        = 8,
  parameter int ADDRWIDTH        = 3,
  parameter     DATA_REGGEN_INIT = 32'h00000000
) (
  input  logic                     SC_RegBANK_CLOCK_50,
  input  logic                     SC_RegGENERAL_Reset_InHigh,
  input  logic                     SC_RegBANK_Write_InHigh,
  input  logic [1:0]               SC_RegBANK_Op_In,
  input  logic [ADDRWIDTH-1:0]     SC_RegBANK_WrAddr_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUS_In,
  input  logic                     SC_RegBANK_ClearDirty_InHigh,
  input  logic [ADDRWIDTH-1:0]     SC_RegBANK_RdAddrA_In,
  input  logic [ADDRWIDTH-1:0]     SC_RegBANK_RdAddrB_In,
  output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSA_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSB_Out,
  output logic                     SC_RegBANK_Carry_Out,
  output logic                     SC_RegBANK_Zero_Out,
  output logic [REG_COUNT-1:0]     SC_RegBANK_Dirty_Out
);

  localparam logic [DATAWIDTH_BUS-1:0] initVal  = DATAWIDTH_BUS'(DATA_REGGEN_INIT);
  // One extra bit so REG_COUNT == 2^ADDRWIDTH is representable.
  localparam logic [ADDRWIDTH:0]       regCountW = (ADDRWIDTH+1)'(REG_COUNT);

  logic [DATAWIDTH_BUS-1:0] regFile [REG_COUNT];
  logic [DATAWIDTH_BUS-1:0] curVal;
  logic [DATAWIDTH_BUS-1:0] nextVal;
  logic [DATAWIDTH_BUS:0]   incSum;
  logic                     nextCarry;
  logic                     wrValid;

  assign wrValid = SC_RegBANK_Write_InHigh && ({1'b0, SC_RegBANK_WrAddr_In} < regCountW);

  // Current value of the target register; a loop avoids indexing past REG_COUNT.
  always_comb begin
    curVal = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (SC_RegBANK_WrAddr_In == ADDRWIDTH'(i)) curVal = regFile[i];
    end
  end

  assign incSum = {1'b0, curVal} + {{DATAWIDTH_BUS{1'b0}}, 1'b1};

  always_comb begin
    nextVal   = '0;
    nextCarry = 1'b0;
    case (SC_RegBANK_Op_In)
      2'b00: begin
        nextVal   = SC_RegBANK_DataBUS_In;
        nextCarry = 1'b0;
      end
      2'b01: begin
        nextVal   = {curVal[DATAWIDTH_BUS-2:0], 1'b0};
        nextCarry = curVal[DATAWIDTH_BUS-1];
      end
      2'b10: begin
        nextVal   = {1'b0, curVal[DATAWIDTH_BUS-1:1]};
        nextCarry = curVal[0];
      end
      default: begin
        nextVal   = incSum[DATAWIDTH_BUS-1:0];
        nextCarry = incSum[DATAWIDTH_BUS];
      end
    endcase
  end

  always_ff @(negedge SC_RegBANK_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      for (int i = 0; i < REG_COUNT; i++) regFile[i] <= initVal;
      SC_RegBANK_Carry_Out <= 1'b0;
      SC_RegBANK_Zero_Out  <= 1'b0;
      SC_RegBANK_Dirty_Out <= '0;
    end else begin
      if (wrValid) begin
        SC_RegBANK_Carry_Out <= nextCarry;
        SC_RegBANK_Zero_Out  <= (nextVal == '0);
      end
      // Clear first, then the write sets its own bit, so a same-cycle write wins.
      for (int i = 0; i < REG_COUNT; i++) begin
        if (SC_RegBANK_ClearDirty_InHigh) SC_RegBANK_Dirty_Out[i] <= 1'b0;
        if (wrValid && (SC_RegBANK_WrAddr_In == ADDRWIDTH'(i))) begin
          regFile[i]              <= nextVal;
          SC_RegBANK_Dirty_Out[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    SC_RegBANK_DataBUSA_Out = '0;
    SC_RegBANK_DataBUSB_Out = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (SC_RegBANK_RdAddrA_In == ADDRWIDTH'(i)) SC_RegBANK_DataBUSA_Out = regFile[i];
      if (SC_RegBANK_RdAddrB_In == ADDRWIDTH'(i)) SC_RegBANK_DataBUSB_Out = regFile[i];
    end
`ifdef SC_REGBANK_READ_BYPASS_EN
    if (wrValid && (SC_RegBANK_RdAddrA_In == SC_RegBANK_WrAddr_In)) SC_RegBANK_DataBUSA_Out = nextVal;
    if (wrValid && (SC_RegBANK_RdAddrB_In == SC_RegBANK_WrAddr_In)) SC_RegBANK_DataBUSB_Out = nextVal;
`endif
  end

endmodule

// File: tb/tb_sc_regbank_multimode.sv
module tb_sc_regbank_multimode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // Default build: 8 registers
  logic        wr = 1'b0, clr = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [2:0]  wrA = '0, rdA = '0, rdB = '0;
  logic [31:0] din = '0;
  logic [31:0] outA, outB;
  logic        carry, zero;
  logic [7:0]  dirty;

  // Second instance: 6 registers
  logic        wr6 = 1'b0, clr6 = 1'b0;
  logic [1:0]  op6 = 2'b00;
  logic [2:0]  wrA6 = '0, rdA6 = '0, rdB6 = '0;
  logic [31:0] din6 = '0;
  logic [31:0] outA6, outB6;
  logic        carry6, zero6;
  logic [5:0]  dirty6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_regbank_multimode dut (
    .SC_RegBANK_CLOCK_50(clk), .SC_RegGENERAL_Reset_InHigh(rst),
    .SC_RegBANK_Write_InHigh(wr), .SC_RegBANK_Op_In(op),
    .SC_RegBANK_WrAddr_In(wrA), .SC_RegBANK_DataBUS_In(din),
    .SC_RegBANK_ClearDirty_InHigh(clr),
    .SC_RegBANK_RdAddrA_In(rdA), .SC_RegBANK_RdAddrB_In(rdB),
    .SC_RegBANK_DataBUSA_Out(outA), .SC_RegBANK_DataBUSB_Out(outB),
    .SC_RegBANK_Carry_Out(carry), .SC_RegBANK_Zero_Out(zero),
    .SC_RegBANK_Dirty_Out(dirty));

  sc_regbank_multimode #(.REG_COUNT(6)) dut6 (
    .SC_RegBANK_CLOCK_50(clk), .SC_RegGENERAL_Reset_InHigh(rst),
    .SC_RegBANK_Write_InHigh(wr6), .SC_RegBANK_Op_In(op6),
    .SC_RegBANK_WrAddr_In(wrA6), .SC_RegBANK_DataBUS_In(din6),
    .SC_RegBANK_ClearDirty_InHigh(clr6),
    .SC_RegBANK_RdAddrA_In(rdA6), .SC_RegBANK_RdAddrB_In(rdB6),
    .SC_RegBANK_DataBUSA_Out(outA6), .SC_RegBANK_DataBUSB_Out(outB6),
    .SC_RegBANK_Carry_Out(carry6), .SC_RegBANK_Zero_Out(zero6),
    .SC_RegBANK_Dirty_Out(dirty6));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on the 8-register bank; returns 1 time unit after the falling edge.
  task automatic doOp(input logic w, input logic c, input logic [1:0] o,
                      input logic [2:0] a, input logic [31:0] d);
    wr = w; clr = c; op = o; wrA = a; din = d;
    @(negedge clk); #1;
    wr = 1'b0; clr = 1'b0;
  endtask

  task automatic doOp6(input logic [1:0] o, input logic [2:0] a, input logic [31:0] d);
    wr6 = 1'b1; op6 = o; wrA6 = a; din6 = d;
    @(negedge clk); #1;
    wr6 = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_outA", outA, 0);
    check("rst_flags", {carry, zero}, 2'b00);
    check("rst_dirty", dirty, 8'h00);
    rst = 1'b0;

    // Load R2, then reset between edges
    rdA = 3'd2;
    doOp(1, 0, 2'b00, 3'd2, 32'h00001234);
    check("load_r2", outA, 32'h00001234);
    check("load_r2_dirty", dirty, 8'h04);
    #2 rst = 1'b1;
    #1;
    check("midrst_outA", outA, 0);
    check("midrst_flags", {carry, zero}, 2'b00);
    check("midrst_dirty", dirty, 8'h00);
    rst = 1'b0;

    // Load then inc wrap
    rdA = 3'd5;
    doOp(1, 0, 2'b00, 3'd5, 32'hFFFFFFFF);
    check("load_r5", outA, 32'hFFFFFFFF);
    check("load_r5_flags", {carry, zero}, 2'b00);
    doOp(1, 0, 2'b11, 3'd5, 32'h0);
    check("inc_wrap_val", outA, 0);
    check("inc_wrap_flags", {carry, zero}, 2'b11);
    check("inc_wrap_dirty", dirty, 8'h20);

    // Clear dirty alone; flags hold
    doOp(0, 1, 2'b00, 3'd0, 32'h0);
    check("clr_dirty", dirty, 8'h00);
    check("clr_flags_hold", {carry, zero}, 2'b11);

    // Shifts on R1
    rdA = 3'd1;
    doOp(1, 0, 2'b00, 3'd1, 32'h80000001);
    check("load_r1_flags", {carry, zero}, 2'b00);
    doOp(1, 0, 2'b01, 3'd1, 32'h0);
    check("shl_val", outA, 32'h00000002);
    check("shl_flags", {carry, zero}, 2'b10);
    doOp(1, 0, 2'b10, 3'd1, 32'h0);
    check("shr1_val", outA, 32'h00000001);
    check("shr1_flags", {carry, zero}, 2'b00);
    doOp(1, 0, 2'b10, 3'd1, 32'h0);
    check("shr2_val", outA, 0);
    check("shr2_flags", {carry, zero}, 2'b11);
    check("shift_dirty", dirty, 8'h02);
    doOp(0, 1, 2'b00, 3'd0, 32'h0);

    // Dual read and Write=0 independence
    doOp(1, 0, 2'b00, 3'd3, 32'hA5A5A5A5);
    doOp(1, 0, 2'b00, 3'd4, 32'h5A5A5A5A);
    rdA = 3'd3; rdB = 3'd4; #1;
    check("dual_A", outA, 32'hA5A5A5A5);
    check("dual_B", outB, 32'h5A5A5A5A);
    doOp(0, 0, 2'b11, 3'd3, 32'h0);
    check("nowrite_val", outA, 32'hA5A5A5A5);
    check("nowrite_flags", {carry, zero}, 2'b00);
    check("dirty_18", dirty, 8'h18);

    // Clear dirty colliding with a write
    doOp(1, 1, 2'b00, 3'd0, 32'h00000007);
    check("collide_dirty", dirty, 8'h01);
    rdA = 3'd0; rdB = 3'd0; #1;
    check("same_A", outA, 32'h7);
    check("same_B", outB, 32'h7);

    // Plain increment without wrap
    doOp(1, 0, 2'b11, 3'd0, 32'h0);
    check("inc_val", outA, 32'h8);
    check("inc_flags", {carry, zero}, 2'b00);

    // Read-port view of a pending write
    rdA = 3'd2; rdB = 3'd4;
    wr = 1'b1; op = 2'b00; wrA = 3'd2; din = 32'hCAFE0000;
    #1;
`ifdef SC_REGBANK_READ_BYPASS_EN
    check("prewrite_A", outA, 32'hCAFE0000);
`else
    check("prewrite_A", outA, 32'h0);
`endif
    check("prewrite_B", outB, 32'h5A5A5A5A);
    @(negedge clk); #1;
    wr = 1'b0;
    check("postwrite_A", outA, 32'hCAFE0000);

    // Six-register bank: out-of-range writes and reads
    rdA6 = 3'd5; rdB6 = 3'd7;
    doOp6(2'b00, 3'd5, 32'h00001234);
    check("r6_load", outA6, 32'h00001234);
    check("r6_dirty", dirty6, 6'h20);
    doOp6(2'b00, 3'd7, 32'h0);
    check("r6_oor7_flags", {carry6, zero6}, 2'b00);
    check("r6_oor7_dirty", dirty6, 6'h20);
    check("r6_rd7", outB6, 0);
    doOp6(2'b11, 3'd6, 32'h0);
    rdB6 = 3'd6; #1;
    check("r6_oor6_dirty", dirty6, 6'h20);
    check("r6_rd6", outB6, 0);
    check("r6_r5_hold", outA6, 32'h00001234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
